// File: rtl/t_ff.sv
// rtl/t_ff.sv - parameterised synchronous toggle flip-flop bank
module t_ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: each bit inverts where its toggle enable is set, else holds.
    always_comb begin
        q_d = q_q ^ T;
    end

    // State register; reset takes priority over any toggle pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_t_ff.sv
// tb/tb_t_ff.sv - directed self-checking bench for t_ff
module tb_t_ff;

    logic       clk;
    logic       rst;
    logic [0:0] t1;
    logic [0:0] q1;
    logic [3:0] t4;
    logic [3:0] q4;

    int checks;
    int errors;

    t_ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .T   (t1),
        .Q   (q1)
    );

    t_ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1010)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .T   (t4),
        .Q   (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        t1  = 1'b0;
        t4  = 4'b0000;

        // Reset edge at 5 ns.
        step();
        chk("reset_q1", {3'b000, q1}, 4'b0000);
        chk("reset_q4", q4, 4'b1010);

        // Continuous toggle: edges 15, 25, 35, 45.
        rst = 1'b0;
        t1  = 1'b1;
        step(); chk("tog15", {3'b000, q1}, 4'b0001);
        step(); chk("tog25", {3'b000, q1}, 4'b0000);
        step(); chk("tog35", {3'b000, q1}, 4'b0001);
        step(); chk("tog45", {3'b000, q1}, 4'b0000);
        chk("q4_hold_t0", q4, 4'b1010);

        // Hold: edges 55, 65.
        t1 = 1'b0;
        step(); chk("hold55", {3'b000, q1}, 4'b0000);
        step(); chk("hold65", {3'b000, q1}, 4'b0000);

        // Resume toggle: edges 75, 85, 95.
        t1 = 1'b1;
        step(); chk("res75", {3'b000, q1}, 4'b0001);
        step(); chk("res85", {3'b000, q1}, 4'b0000);
        step(); chk("res95", {3'b000, q1}, 4'b0001);

        // Reset priority over toggle at edge 105.
        rst = 1'b1;
        t1  = 1'b1;
        t4  = 4'b1111;
        step(); chk("rstprio_q1", {3'b000, q1}, 4'b0000);
        chk("rstprio_q4", q4, 4'b1010);

        // Release reset with T=1: toggles from RST_VAL at edge 115.
        rst = 1'b0;
        t4  = 4'b0000;
        step(); chk("release_q1", {3'b000, q1}, 4'b0001);

        // Reset pulse between edges only: no effect.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk("pulse_noimm", {3'b000, q1}, 4'b0001);
        step(); chk("pulse_edge", {3'b000, q1}, 4'b0000);

        // Multi-bit mixed patterns.
        t1 = 1'b0;
        t4 = 4'b0110;
        step(); chk("mb_0110", q4, 4'b1100);
        t4 = 4'b1111;
        step(); chk("mb_1111", q4, 4'b0011);
        t4 = 4'b0001;
        step(); chk("mb_0001", q4, 4'b0010);
        chk("q1_hold_mb", {3'b000, q1}, 4'b0000);

        // Mid-operation reset discards toggle, then resumes from RST_VAL.
        rst = 1'b1;
        t4  = 4'b0101;
        step(); chk("mb_rst", q4, 4'b1010);
        rst = 1'b0;
        step(); chk("mb_resume", q4, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
